// File: rtl/rr_arbiter8_if.sv
// Arbiter request/grant bundle: en/req in, one-hot and encoded grant out.
// master = requester side, slave = arbiter side.
interface rr_arbiter8_if;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       expired;

  modport master (
    output en, req,
    input  gnt, gnt_id, gnt_valid, expired
  );

  modport slave (
    input  en, req,
    output gnt, gnt_id, gnt_valid, expired
  );
endinterface

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with hold limit; all outputs registered.
// Ports: clk, rst (sync, active-high), bus (slave: en, req -> gnt/gnt_id/gnt_valid/expired).
module rr_arbiter8 #(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input logic         clk,
  input logic         rst,
  rr_arbiter8_if.slave bus
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       gnt_id_q, gnt_id_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             expired_q, expired_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic       found;
  logic [2:0] win;

  // ptr is lowest priority; scan ptr+1 .. ptr+8 (mod 8).
  always_comb begin
    logic [2:0] idx;
    idx   = '0;
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= 8; k++) begin
      idx = ptr_q + 3'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_id_d    = gnt_id_q;
    gnt_valid_d = gnt_valid_q;
    ptr_d       = ptr_q;
    hold_d      = hold_q;
    expired_d   = 1'b0;

    if (!bus.en) begin
      state_d     = IDLE;
      gnt_d       = '0;
      gnt_id_d    = '0;
      gnt_valid_d = 1'b0;
      hold_d      = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            state_d     = OWN;
            gnt_d       = 8'b1 << win;
            gnt_id_d    = win;
            gnt_valid_d = 1'b1;
            ptr_d       = win;
            hold_d      = '0;
          end
        end
        OWN: begin
          if (bus.req[gnt_id_q] &&
              (MAX_HOLD == 0 || hold_q < HOLD_LAST)) begin
            hold_d = hold_q + 1'b1;
          end else begin
            // Release or expiry. ptr_q == gnt_id_q here, so the
            // current owner is searched last and may be re-granted.
            expired_d = bus.req[gnt_id_q];
            if (found) begin
              gnt_d       = 8'b1 << win;
              gnt_id_d    = win;
              gnt_valid_d = 1'b1;
              ptr_d       = win;
              hold_d      = '0;
            end else begin
              state_d     = IDLE;
              gnt_d       = '0;
              gnt_id_d    = '0;
              gnt_valid_d = 1'b0;
              hold_d      = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_id_q    <= '0;
      gnt_valid_q <= 1'b0;
      expired_q   <= 1'b0;
      ptr_q       <= 3'd7;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_id_q    <= gnt_id_d;
      gnt_valid_q <= gnt_valid_d;
      expired_q   <= expired_d;
      ptr_q       <= ptr_d;
      hold_q      <= hold_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.expired   = expired_q;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Bench for rr_arbiter8 (MAX_HOLD=4): directed steps plus random traffic
// against an owner/age reference model.
module tb_rr_arbiter8;

  localparam int MH = 4;

  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;

  rr_arbiter8_if bus ();

  rr_arbiter8 #(.MAX_HOLD(MH), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference: who owns, how many cycles it has owned, who was last granted.
  int owner = -1;
  int age   = 0;
  int ptr   = 7;
  logic m_exp;

  function automatic int pick(input logic [7:0] r, input int p);
    for (int k = 1; k <= 8; k++)
      if (r[(p + k) % 8]) return (p + k) % 8;
    return -1;
  endfunction

  task automatic model_step(input logic r, input logic e, input logic [7:0] q);
    int w;
    m_exp = 1'b0;
    if (r) begin
      owner = -1; age = 0; ptr = 7;
    end else if (!e) begin
      owner = -1; age = 0;
    end else if (owner < 0) begin
      w = pick(q, ptr);
      if (w >= 0) begin owner = w; ptr = w; age = 1; end
    end else if (q[owner] && age < MH) begin
      age++;
    end else begin
      m_exp = q[owner];
      w = pick(q, ptr);
      if (w >= 0) begin owner = w; ptr = w; age = 1; end
      else begin owner = -1; age = 0; end
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: apply inputs, step model, check outputs #1 after the edge.
  task automatic cyc(input logic r, input logic e, input logic [7:0] q);
    logic [7:0] eg;
    rst = r; bus.en = e; bus.req = q;
    @(posedge clk);
    model_step(r, e, q);
    #1;
    eg = (owner < 0) ? 8'h00 : 8'(1 << owner);
    chk("gnt", bus.gnt, eg);
    chk("gnt_id", 8'(bus.gnt_id), (owner < 0) ? 8'h00 : 8'(owner));
    chk("gnt_valid", 8'(bus.gnt_valid), 8'(owner >= 0));
    chk("expired", 8'(bus.expired), 8'(m_exp));
    chk("onehot", 8'($onehot0(bus.gnt)), 8'h01);
    chk("valid_or", 8'(bus.gnt_valid), 8'(|bus.gnt));
  endtask

  initial begin
    logic [7:0] q;
    logic       e;
    logic       r;
    int         o;

    // 1: single requester
    cyc(1, 1, 8'h00);
    chk("rst_gnt", bus.gnt, 8'h00);
    cyc(0, 1, 8'h01);
    chk("t1_gnt", bus.gnt, 8'h01);
    chk("t1_id", 8'(bus.gnt_id), 8'h00);
    cyc(0, 1, 8'h01);
    cyc(0, 1, 8'h01);
    cyc(0, 1, 8'h00);
    chk("t1_drop", bus.gnt, 8'h00);

    // 2: owner releases right after grant -> 0..7,0 with no gaps
    cyc(1, 1, 8'h00);
    cyc(0, 1, 8'hFF);
    chk("t2_first", 8'(bus.gnt_id), 8'h00);
    for (int i = 1; i <= 8; i++) begin
      o = int'(bus.gnt_id);
      cyc(0, 1, 8'hFF & ~8'(1 << o));
      chk("t2_seq", 8'(bus.gnt_id), 8'(i % 8));
      chk("t2_nogap", 8'(bus.gnt_valid), 8'h01);
    end

    // 3: two requesters share with hold limit 4
    cyc(1, 1, 8'h00);
    for (int i = 1; i <= 9; i++) begin
      cyc(0, 1, 8'h05);
      chk("t3_gnt", bus.gnt, (((i - 1) / 4) % 2 == 1) ? 8'h04 : 8'h01);
      chk("t3_exp", 8'(bus.expired), 8'(i > 1 && (i - 1) % 4 == 0));
    end

    // 4: lone requester re-granted, expired every 4 cycles
    cyc(1, 1, 8'h00);
    for (int i = 1; i <= 13; i++) begin
      cyc(0, 1, 8'h08);
      chk("t4_gnt", bus.gnt, 8'h08);
      chk("t4_exp", 8'(bus.expired), 8'(i > 1 && (i - 1) % 4 == 0));
    end

    // 5: enable drop keeps the pointer
    cyc(1, 1, 8'h00);
    cyc(0, 1, 8'h08);
    chk("t5_own3", bus.gnt, 8'h08);
    cyc(0, 0, 8'h18);
    chk("t5_off", bus.gnt, 8'h00);
    cyc(0, 0, 8'h18);
    chk("t5_off2", bus.gnt, 8'h00);
    cyc(0, 1, 8'h18);
    chk("t5_resume", bus.gnt, 8'h10);

    // 6: reset mid-grant
    cyc(0, 1, 8'h80);
    cyc(0, 1, 8'h80);
    cyc(1, 1, 8'h80);
    chk("t6_rst_gnt", bus.gnt, 8'h00);
    chk("t6_rst_exp", 8'(bus.expired), 8'h00);
    cyc(0, 1, 8'h80);
    chk("t6_regrant", bus.gnt, 8'h80);

    // Random traffic: sticky requests so holds and expiries occur.
    q = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) q = 8'($urandom);
      if ($urandom_range(5) == 0 && owner >= 0) q[owner] = 1'b0;
      e = ($urandom_range(15) != 0);
      r = ($urandom_range(99) == 0);
      cyc(r, e, q);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
